// File: rtl/tt_um_emern_frame_ctrl_if.sv
// Byte-serial descriptor port for the frame sequencer.
interface tt_um_emern_frame_ctrl_if;
  logic       cfg_valid;
  logic       cfg_sof;
  logic [7:0] cfg_data;
  logic       cfg_ready;

  modport master (output cfg_valid, cfg_sof, cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, cfg_sof, cfg_data, output cfg_ready);
endinterface

// File: rtl/tt_um_emern_frame_ctrl.sv
// Frame sequencer: VGA scan timing, descriptor shadow loader and
// vblank-synchronous commit of live pixel-core parameters.
// Optional: define FRAME_COUNT_EN to add an 8-bit frame_count output.
module tt_um_emern_frame_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                            clk,
  input  logic                            rst_n,
  tt_um_emern_frame_ctrl_if.slave         cfg,
  output logic [8:0]                      pixel_row,
  output logic [9:0]                      pixel_col,
  output logic [1:0]                      cmp_en,
  output logic [5:0]                      background_color,
  output logic [11:0]                     poly_color,
  output logic [13:0]                     v0_x,
  output logic [13:0]                     v1_x,
  output logic [13:0]                     v2_x,
  output logic [11:0]                     v0_y,
  output logic [11:0]                     v1_y,
  output logic [11:0]                     v2_y,
  output logic                            hsync,
  output logic                            vsync,
  output logic                            de,
`ifdef FRAME_COUNT_EN
  output logic [7:0]                      frame_count,
`endif
  output logic                            swap_pulse
);

  localparam logic [9:0] HA   = 10'(H_ACTIVE);
  localparam logic [9:0] HS0  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] HMAX = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VA   = 10'(V_ACTIVE);
  localparam logic [9:0] VS0  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VMAX = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  // Descriptor bits above 97 are never used, so they are not stored.
  localparam int LIVE_W = 98;

  typedef enum logic {LOAD, PENDING} state_t;

  state_t              state_q, state_d;
  logic [9:0]          h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [3:0]          byte_cnt_q, byte_cnt_d, wr_idx;
  logic [LIVE_W-1:0]   shadow_q, shadow_d, live_q, live_d;
  logic                hsync_q, vsync_q, de_q, swap_q, swap_d;
  logic                hsync_raw, vsync_raw, de_raw, swap_evt, xfer;

  // Scan counters: h wraps every line, v advances on each h wrap.
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HMAX) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VMAX) ? '0 : v_cnt_q + 10'd1;
    end
  end

  // Raw strobes and pixel coordinates straight from the counters.
  always_comb begin
    hsync_raw = !(h_cnt_q >= HS0 && h_cnt_q < HS1);
    vsync_raw = !(v_cnt_q >= VS0 && v_cnt_q < VS1);
    de_raw    = (h_cnt_q < HA) && (v_cnt_q < VA);
    swap_evt  = (h_cnt_q == '0) && (v_cnt_q == VA);
    pixel_col = (h_cnt_q < HA) ? h_cnt_q : '0;
    pixel_row = (v_cnt_q < VA) ? v_cnt_q[8:0] : '0;
  end

  // Loader FSM: fill shadow bytewise, then wait for vblank to commit.
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    shadow_d      = shadow_q;
    live_d        = live_q;
    swap_d        = 1'b0;
    cfg.cfg_ready = (state_q == LOAD);
    xfer          = cfg.cfg_valid && (state_q == LOAD);
    wr_idx        = cfg.cfg_sof ? 4'd0 : byte_cnt_q;
    case (state_q)
      LOAD: begin
        // A last byte landing on the swap clock itself commits next vblank,
        // since the commit only looks at PENDING.
        if (xfer) begin
          for (int i = 0; i < LIVE_W; i++)
            if (4'(i / 8) == wr_idx) shadow_d[7'(i)] = cfg.cfg_data[3'(i % 8)];
          if (!cfg.cfg_sof && byte_cnt_q == 4'd12) begin
            state_d    = PENDING;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = wr_idx + 4'd1;
          end
        end
      end
      PENDING: begin
        if (swap_evt) begin
          live_d  = shadow_q;
          swap_d  = 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // State, counters, descriptor storage and one-cycle-delayed strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      byte_cnt_q <= '0;
      shadow_q   <= '0;
      live_q     <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      de_q       <= 1'b0;
      swap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shadow_q   <= shadow_d;
      live_q     <= live_d;
      hsync_q    <= hsync_raw;
      vsync_q    <= vsync_raw;
      de_q       <= de_raw;
      swap_q     <= swap_d;
    end
  end

`ifdef FRAME_COUNT_EN
  logic [7:0] frame_count_q, frame_count_d;

  // Frame counter bumps on every swap event, committed or not.
  always_comb begin
    frame_count_d = frame_count_q;
    if (swap_evt) frame_count_d = frame_count_q + 8'd1;
  end

  // Frame counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_count_q <= '0;
    else        frame_count_q <= frame_count_d;
  end

  assign frame_count = frame_count_q;
`endif

  assign hsync            = hsync_q;
  assign vsync            = vsync_q;
  assign de               = de_q;
  assign swap_pulse       = swap_q;
  assign poly_color       = live_q[11:0];
  assign v0_x             = live_q[25:12];
  assign v0_y             = live_q[37:26];
  assign v1_x             = live_q[51:38];
  assign v1_y             = live_q[63:52];
  assign v2_x             = live_q[77:64];
  assign v2_y             = live_q[89:78];
  assign cmp_en           = live_q[91:90];
  assign background_color = live_q[97:92];

endmodule

// File: tb/tb_tt_um_emern_frame_ctrl.sv
// Bench for tt_um_emern_frame_ctrl: a default-timing instance checks the
// real 800-clock line, a shrunken-timing instance runs whole frames against
// a time-indexed reference model with random descriptor traffic.
module tb_tt_um_emern_frame_ctrl;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0, rst_n = 1'b0, rst_nd = 1'b0;
  always #5 clk = ~clk;

  tt_um_emern_frame_ctrl_if cfg();
  tt_um_emern_frame_ctrl_if cfgd();

  logic [8:0]  pixel_row, d_row;
  logic [9:0]  pixel_col, d_col;
  logic [1:0]  cmp_en, d_cmp;
  logic [5:0]  bg, d_bg;
  logic [11:0] poly, v0_y, v1_y, v2_y, d_poly, d_v0y, d_v1y, d_v2y;
  logic [13:0] v0_x, v1_x, v2_x, d_v0x, d_v1x, d_v2x;
  logic        hsync, vsync, de, swap_pulse, d_hs, d_vs, d_de, d_swap;
`ifdef FRAME_COUNT_EN
  logic [7:0]  frame_count, d_fc;
`endif

  tt_um_emern_frame_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                           .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cfg.slave),
    .pixel_row(pixel_row), .pixel_col(pixel_col), .cmp_en(cmp_en),
    .background_color(bg), .poly_color(poly),
    .v0_x(v0_x), .v1_x(v1_x), .v2_x(v2_x), .v0_y(v0_y), .v1_y(v1_y), .v2_y(v2_y),
    .hsync(hsync), .vsync(vsync), .de(de),
`ifdef FRAME_COUNT_EN
    .frame_count(frame_count),
`endif
    .swap_pulse(swap_pulse));

  tt_um_emern_frame_ctrl dut_d (
    .clk(clk), .rst_n(rst_nd), .cfg(cfgd.slave),
    .pixel_row(d_row), .pixel_col(d_col), .cmp_en(d_cmp),
    .background_color(d_bg), .poly_color(d_poly),
    .v0_x(d_v0x), .v1_x(d_v1x), .v2_x(d_v2x), .v0_y(d_v0y), .v1_y(d_v1y), .v2_y(d_v2y),
    .hsync(d_hs), .vsync(d_vs), .de(d_de),
`ifdef FRAME_COUNT_EN
    .frame_count(d_fc),
`endif
    .swap_pulse(d_swap));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (time-indexed) ----------------
  int          t;          // clocks since reset release == scan position
  logic [7:0]  sb [13];    // shadow descriptor bytes
  int          idx;
  bit          pend, rnd_mode;
  logic [97:0] live_m;
  bit          swp_m, hs_m, vs_m, de_m;
  int          fc_m;
  logic [9:0]  q [$];      // {valid, sof, data}

  function automatic logic [97:0] pack_desc();
    logic [103:0] w;
    for (int k = 0; k < 13; k++) w[8*k +: 8] = sb[k];
    return w[97:0];
  endfunction

  task automatic check_all();
    int h, v;
    h = t % HT; v = (t / HT) % VT;
    chk("pixel_col", pixel_col, (h < HA) ? h : 0);
    chk("pixel_row", pixel_row, (v < VA) ? v : 0);
    chk("hsync", hsync, hs_m);
    chk("vsync", vsync, vs_m);
    chk("de", de, de_m);
    chk("swap_pulse", swap_pulse, swp_m);
    chk("poly_color", poly, live_m[11:0]);
    chk("v0_x", v0_x, live_m[25:12]);
    chk("v0_y", v0_y, live_m[37:26]);
    chk("v1_x", v1_x, live_m[51:38]);
    chk("v1_y", v1_y, live_m[63:52]);
    chk("v2_x", v2_x, live_m[77:64]);
    chk("v2_y", v2_y, live_m[89:78]);
    chk("cmp_en", cmp_en, live_m[91:90]);
    chk("bg_color", bg, live_m[97:92]);
`ifdef FRAME_COUNT_EN
    chk("frame_count", frame_count, fc_m % 256);
`endif
  endtask

  // One clock: drive at negedge, predict the edge, compare after it.
  task automatic step();
    logic [9:0] e;
    int h, v;
    bit swp;
    @(negedge clk);
    if (q.size() > 0 && !pend) e = q.pop_front();
    else if (rnd_mode) e = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), 8'($urandom)};
    else e = '0;
    cfg.cfg_valid = e[9]; cfg.cfg_sof = e[8]; cfg.cfg_data = e[7:0];
    #1 chk("cfg_ready", cfg.cfg_ready, !pend);
    h = t % HT; v = (t / HT) % VT;
    swp = (h == 0) && (v == VA);
    swp_m = 0;
    if (swp) fc_m++;
    if (pend) begin
      if (swp) begin live_m = pack_desc(); swp_m = 1; pend = 0; end
    end else if (e[9]) begin
      if (e[8]) begin sb[0] = e[7:0]; idx = 1; end
      else begin
        sb[idx] = e[7:0];
        if (idx == 12) begin idx = 0; pend = 1; end else idx++;
      end
    end
    hs_m = !(h >= HA + HF && h < HA + HF + HS);
    vs_m = !(v >= VA + VF && v < VA + VF + VS);
    de_m = (h < HA) && (v < VA);
    t++;
    @(posedge clk); #1;
    check_all();
  endtask

  // Async reset between edges; outputs must drop before any clock.
  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("rst_hsync", hsync, 1); chk("rst_vsync", vsync, 1);
    chk("rst_de", de, 0);       chk("rst_swap", swap_pulse, 0);
    chk("rst_poly", poly, 0);   chk("rst_v2y", v2_y, 0);
    chk("rst_bg", bg, 0);       chk("rst_cmp", cmp_en, 0);
    chk("rst_col", pixel_col, 0); chk("rst_row", pixel_row, 0);
    chk("rst_ready", cfg.cfg_ready, 1);
    t = 0; idx = 0; pend = 0; live_m = '0; swp_m = 0;
    hs_m = 1; vs_m = 1; de_m = 0; fc_m = 0; q.delete();
    for (int k = 0; k < 13; k++) sb[k] = '0;
    cfg.cfg_valid = 0; cfg.cfg_sof = 0; cfg.cfg_data = '0;
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic run_until_swap();
    bit seen = 0;
    for (int i = 0; i < 2 * FT + 20 && !seen; i++) begin
      step();
      if (swap_pulse) seen = 1;
    end
    chk("swap_seen", seen, 1);
  endtask

  task automatic push_desc(input logic [7:0] b0, input logic [7:0] b1, input bit rnd_rest);
    q.push_back({2'b11, b0});
    q.push_back({2'b10, b1});
    for (int k = 2; k < 13; k++) q.push_back({2'b10, rnd_rest ? 8'($urandom) : 8'h00});
  endtask

  initial begin
    int de_n, hs_n, vs_n, first_low, low_n, bound;
    logic [7:0] b0, b1;
    cfg.cfg_valid = 0; cfg.cfg_sof = 0; cfg.cfg_data = '0;
    cfgd.cfg_valid = 0; cfgd.cfg_sof = 0; cfgd.cfg_data = '0;
    rnd_mode = 0;

    // Real 640x480 timing: first two lines of the default instance.
    @(posedge clk); #2 rst_nd = 1'b1;
    first_low = -1; low_n = 0;
    for (int c = 0; c < 1700; c++) begin
      int hp, hn;
      @(posedge clk); #1;
      hp = c % 800; hn = (c + 1) % 800;
      chk("d_hsync", d_hs, !(hp >= 656 && hp < 752));
      chk("d_de", d_de, hp < 640);
      chk("d_vsync", d_vs, 1);
      chk("d_col", d_col, (hn < 640) ? hn : 0);
      chk("d_row", d_row, (c + 1) / 800);
      if (c < 800 && !d_hs) begin
        low_n++;
        if (first_low < 0) first_low = hn;
      end
    end
    chk("d_hs_low_cnt", low_n, 96);
    chk("d_hs_first_low", first_low, 657);

    // Small-timing instance.
    do_reset();

    // Two idle frames; per-frame strobe totals on the first.
    de_n = 0; hs_n = 0; vs_n = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      step();
      if (i < FT) begin de_n += de; hs_n += !hsync; vs_n += !vsync; end
    end
    chk("de_per_frame", de_n, HA * VA);
    chk("hs_low_per_frame", hs_n, HS * VT);
    chk("vs_low_per_frame", vs_n, VS * HT);

    // Basic descriptor commit.
    push_desc(8'h3F, 8'h0F, 0);
    run_until_swap();
    chk("commit_poly", poly, 12'hF3F);

    // Resync: 5 stale bytes, then sof restarts the descriptor.
    for (int k = 0; k < 5; k++) q.push_back({2'b10, 8'($urandom)});
    q.push_back({2'b11, 8'hAA});
    for (int k = 0; k < 12; k++) q.push_back({2'b10, 8'($urandom)});
    run_until_swap();
    chk("resync_poly_lo", poly[7:0], 8'hAA);

    // Random input hammered during PENDING must not disturb the shadow.
    b0 = 8'($urandom); b1 = 8'($urandom);
    push_desc(b0, b1, 1);
    rnd_mode = 1;
    run_until_swap();
    chk("pend_hold_poly", poly, {b1[3:0], b0});
    rnd_mode = 0;
    if (pend) run_until_swap();

    // Last byte lands exactly on the swap clock: commit slips a frame.
    bound = 0;
    while ((t % FT) != VA * HT - 12 && bound < 2 * FT) begin step(); bound++; end
    chk("align_bound", bound < 2 * FT, 1);
    b0 = 8'($urandom); b1 = 8'($urandom);
    q.push_back({2'b11, b0}); q.push_back({2'b10, b1});
    for (int k = 2; k < 13; k++) q.push_back({2'b10, 8'($urandom)});
    for (int k = 0; k < 13; k++) step();
    chk("b12_on_swap_nopulse", swap_pulse, 0);
    run_until_swap();
    chk("b12_late_commit", poly, {b1[3:0], b0});

    // Random soak.
    rnd_mode = 1;
    for (int i = 0; i < 5 * FT; i++) step();
    rnd_mode = 0;
    if (pend) run_until_swap();

    // Reset mid-line while a descriptor is pending.
    push_desc(8'h5A, 8'h03, 1);
    bound = 0;
    while (!(pend && (t % HT) == 5) && bound < 2 * FT) begin step(); bound++; end
    chk("pend_midline_bound", bound < 2 * FT, 1);
    do_reset();
    for (int i = 0; i < 2 * FT; i++) step();
    chk("post_rst_poly", poly, 0);

`ifdef FRAME_COUNT_EN
    do_reset();
    for (int i = 0; i < 257 * FT; i++) step();
    chk("frame_count_257", frame_count, 8'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tt_um_emern_frame_ctrl.md
Name: tt_um_emern_frame_ctrl

Overview:
Frame sequencer for the pixel core. Generates 640x480 VGA scan timing (pixel_row/pixel_col plus sync/blank strobes) and delays the strobes to match the pixel core's 1-cycle output register. Accepts a byte-serial polygon/scene descriptor over a valid/ready port and holds it in a shadow register. Commits the descriptor to the live parameters driving the pixel core only at vblank start, so no frame ever shows a partial update.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  descriptor byte valid
cfg_sof  in  1  with cfg_valid: this byte is byte 0 of a descriptor
cfg_data  in  8  descriptor byte
cfg_ready  out  1  controller accepts a byte this cycle
pixel_row  out  9  current row to pixel core
pixel_col  out  10  current column to pixel core
cmp_en  out  2  live polygon enables
background_color  out  6  live background colour
poly_color  out  12  live packed polygon colours
v0_x, v1_x, v2_x  out  14 each  live packed x vertices
v0_y, v1_y, v2_y  out  12 each  live packed y vertices
hsync, vsync  out  1 each  active-low syncs, delayed 1 clock
de  out  1  display enable, delayed 1 clock
swap_pulse  out  1  1-clock pulse when the shadow is committed

Behaviour:
- Reset (async assert, sync-released use):
  - h_cnt = 0, v_cnt = 0, byte_cnt = 0, state LOAD.
  - All live and shadow parameters 0.
  - hsync = 1, vsync = 1, de = 0, swap_pulse = 0.
  - cfg_ready = 1 on the first clock after release.
- Counters:
  - h_cnt counts 0..H_TOT-1, where H_TOT = sum of H params (800).
  - v_cnt advances when h_cnt wraps and counts 0..V_TOT-1 (525).
- pixel_col = h_cnt when h_cnt < H_ACTIVE, else 0. pixel_row = v_cnt[8:0] when v_cnt < V_ACTIVE, else 0. Both are combinational from the counters.
- Raw sync strobes:
  - hsync_raw = 0 for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync_raw follows the same rule on v_cnt.
  - de_raw = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
  - hsync, vsync and de are these registered once, aligning them with pixel_out.
- Descriptor format: 13 bytes, little-endian, 104 bits. Byte k fills bits [8k+7:8k].
  - [11:0] poly_color, [25:12] v0_x, [37:26] v0_y, [51:38] v1_x, [63:52] v1_y, [77:64] v2_x, [89:78] v2_y, [91:90] cmp_en, [97:92] background_color, [103:98] ignored.
- Loader FSM:
  - LOAD: cfg_ready = 1. A byte transfers when cfg_valid and cfg_ready. If cfg_sof is set, the byte is written as byte 0 and byte_cnt becomes 1 (resync mid-descriptor). Otherwise the byte is written at byte_cnt and byte_cnt increments. Transfer of byte 12 -> PENDING, byte_cnt = 0.
  - PENDING: cfg_ready = 0; input is ignored.
- Swap event: the clock where h_cnt = 0 and v_cnt = V_ACTIVE.
  - In PENDING: live <= shadow, swap_pulse = 1, state -> LOAD.
  - In LOAD: no copy, and a partial descriptor is kept.
  - If byte 12 transfers on the swap clock itself, no commit happens; the descriptor commits at the next vblank.
- Live outputs change only on a swap, never mid-frame.

Optional Feature:
FRAME_COUNT_EN
- Defined: adds output frame_count[7:0], reset 0. It increments (wrapping 255 -> 0) on every swap event clock, whether or not a commit occurred.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Release reset, run 2 frames -> hsync low exactly 96 clocks per 800-clock line, first low at h_cnt 657 (delayed 1); vsync low 2 lines per 525-line frame; de high 640x480 clocks per frame.
- Send a 13-byte descriptor with byte0 = 0x3F, byte1 = 0x0F, others 0, mid-frame -> cfg_ready drops after byte 12; poly_color stays 0 until the clock after h_cnt 0 / v_cnt 480, then reads 0xF3F; swap_pulse high 1 clock; cfg_ready returns 1.
- Send 5 bytes, then cfg_sof with byte 0xAA, then 12 more bytes -> committed poly_color[7:0] = 0xAA; earlier bytes discarded.
- Hold cfg_valid high during PENDING with varying data -> no shadow change; the committed value equals the first descriptor.
- Assert rst_n low mid-line while PENDING -> all outputs return to reset values immediately (before the next clk edge); after release, cfg_ready = 1 and the live parameters are 0.
- With FRAME_COUNT_EN defined, run 257 frames -> frame_count = 1.
